// File: rtl/cdc_sync_filter.sv
// Multi-bit level synchronizer with per-bit stability filter and edge pulses.
// Each bit is independent; no coherency between bits is implied.
module cdc_sync_filter #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter int               FILTER    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int CNT_W = (FILTER > 0) ? $clog2(FILTER + 1) : 1;

  if (STAGES < 2) begin : g_bad_stages
    $error("cdc_sync_filter: STAGES must be >= 2");
  end

  // Chain flops: the first one samples async_i directly with nothing in front.
  (* ASYNC_REG = "TRUE", KEEP = "TRUE" *)
  logic [STAGES-1:0][WIDTH-1:0] chain_q;
  logic [WIDTH-1:0]             chain_out;
  logic [WIDTH-1:0]             level;
  logic [WIDTH-1:0]             hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
    end
  end

  assign chain_out = chain_q[STAGES-1];

  if (FILTER == 0) begin : g_nofilt
    // Unfiltered: the last chain flop is the output register.
    assign level = chain_out;
  end else begin : g_filt
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            filt_q, filt_d;

    // Counter only runs while the chain disagrees with the output; it is
    // cleared on commit or on agreement, so it never exceeds FILTER-1.
    always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      for (int b = 0; b < WIDTH; b++) begin
        if (chain_out[b] == filt_q[b]) begin
          cnt_d[b] = '0;
        end else if (cnt_q[b] == CNT_W'(FILTER - 1)) begin
          filt_d[b] = chain_out[b];
          cnt_d[b]  = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q  <= '0;
        filt_q <= RESET_VAL;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign level = filt_q;
  end

  // History loads RESET_VAL alongside the output so reset never makes a pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= RESET_VAL;
    end else begin
      hist_q <= level;
    end
  end

  assign sync_o = level;
  assign rise_o = level & ~hist_q;
  assign fall_o = ~level & hist_q;

endmodule
